rt_param_ctrl: RTL and testbench

Sequencing and arbitration controller for the shared Montgomery-parameter engine (rtMod). Accepts modulus requests from up to NUM_REQ clients (e.g. the encrypt and decrypt paths, needing parameters for n and n²). Arbitrates round-robin and runs the engine twice per miss: mode R (r = 2^RSA_WIDTH mod n), then mode T (t = r² mod n). Caches the last (n, r, t) triple so repeated moduli return without engine use.

---
 rtl/rt_param_ctrl_pkg.sv | 24 ++
 rtl/rt_param_ctrl_rr_arbiter.sv | 53 +++++
 rtl/rt_param_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_rt_param_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rt_param_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the Montgomery-parameter controller.
package rt_param_ctrl_pkg;

   localparam int RSA_WIDTH_DEF = 4096;

   localparam logic OP_R = 1'b0;
   localparam logic OP_T = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_GO_R,
      ST_WAIT_R,
      ST_GO_T,
      ST_WAIT_T,
      ST_RSP
   } state_t;

   // Index width that stays legal for a single requester.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rt_param_ctrl_rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last granted client.
module rr_arbiter
   import rt_param_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDW     = id_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     grant_id
);

   logic [IDW-1:0] ptr_reg;
   logic [IDW-1:0] ptr_next;
   logic [IDW-1:0] cand [NUM_REQ];
   logic           found;

   // cand[k] is the client examined k-th, counting from the pointer.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      localparam logic [IDW:0] OFF = (IDW+1)'(gi);
      localparam logic [IDW:0] NR  = (IDW+1)'(NUM_REQ);
      logic [IDW:0] sum;
      assign sum      = {1'b0, ptr_reg} + OFF;
      assign cand[gi] = IDW'((sum >= NR) ? sum - NR : sum);
   end

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[cand[k]]) begin
            found          = 1'b1;
            grant[cand[k]] = 1'b1;
            grant_id       = cand[k];
         end
      end
   end

   assign ptr_next = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else if (advance && found) begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/rt_param_ctrl.sv
// Arbitrates modulus requests, runs the rtMod engine for r then t on a miss,
// and caches the last (n, r, t) triple.
module rt_param_ctrl
   import rt_param_ctrl_pkg::*;
#(
   parameter int RSA_WIDTH   = RSA_WIDTH_DEF,
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 4095
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*RSA_WIDTH-1:0] req_n,
   input  logic                         cache_flush,
   output logic [NUM_REQ-1:0]           ack,
   output logic [RSA_WIDTH-1:0]         rsp_r,
   output logic [RSA_WIDTH-1:0]         rsp_t,
   output logic                         rsp_err,
   output logic                         eng_go,
   output logic                         eng_mode,
   output logic [RSA_WIDTH-1:0]         eng_n,
   input  logic [RSA_WIDTH-1:0]         eng_r,
   input  logic                         eng_done
);

   localparam int IDW = id_width(NUM_REQ);
   localparam int CW  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYC);

   state_t               state_reg, state_next;
   logic [IDW-1:0]       id_reg;
   logic [RSA_WIDTH-1:0] n_lat_reg;
   logic [RSA_WIDTH-1:0] r_reg;
   logic [RSA_WIDTH-1:0] t_reg;
   logic                 err_reg;
   logic                 miss_reg;
   logic                 flush_flag_reg;
   logic                 cache_vld_reg;
   logic [RSA_WIDTH-1:0] cache_n_reg;
   logic [RSA_WIDTH-1:0] cache_r_reg;
   logic [RSA_WIDTH-1:0] cache_t_reg;
   logic [CW-1:0]        cnt_reg, cnt_next, cnt_inc;

   logic [NUM_REQ-1:0]   grant;
   logic [IDW-1:0]       grant_id;
   logic [RSA_WIDTH-1:0] req_slice [NUM_REQ];
   logic [RSA_WIDTH-1:0] n_sel;

   logic latch, hit, cap_r, cap_t, timeout, in_flight, cache_write;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_slice[gi] = req_n[gi*RSA_WIDTH +: RSA_WIDTH];
      assign ack[gi]       = (state_reg == ST_RSP) && (id_reg == IDW'(gi));
   end

   always_comb begin
      n_sel = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) n_sel = n_sel | req_slice[k];
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_valid),
      .advance  (latch),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign cnt_inc = cnt_reg + CW'(1);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      latch      = 1'b0;
      hit        = 1'b0;
      cap_r      = 1'b0;
      cap_t      = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (|req_valid) begin
               latch      = 1'b1;
               state_next = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            // A flush in this very cycle forces a miss rather than serving stale data.
            hit        = cache_vld_reg && !cache_flush && (n_lat_reg == cache_n_reg);
            state_next = hit ? ST_RSP : ST_GO_R;
         end
         ST_GO_R: begin
            cnt_next   = '0;
            state_next = ST_WAIT_R;
         end
         ST_WAIT_R: begin
            cnt_next = cnt_inc;
            if (eng_done && (cnt_reg != '0)) begin
               cap_r      = 1'b1;
               state_next = ST_GO_T;
            end else if (cnt_inc == TO_LIMIT) begin
               timeout    = 1'b1;
               state_next = ST_RSP;
            end
         end
         ST_GO_T: begin
            cnt_next   = '0;
            state_next = ST_WAIT_T;
         end
         ST_WAIT_T: begin
            cnt_next = cnt_inc;
            if (eng_done && (cnt_reg != '0)) begin
               cap_t      = 1'b1;
               state_next = ST_RSP;
            end else if (cnt_inc == TO_LIMIT) begin
               timeout    = 1'b1;
               state_next = ST_RSP;
            end
         end
         ST_RSP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign in_flight   = (state_reg == ST_GO_R) || (state_reg == ST_WAIT_R) ||
                        (state_reg == ST_GO_T) || (state_reg == ST_WAIT_T);
   assign cache_write = (state_reg == ST_RSP) && miss_reg && !err_reg && !flush_flag_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_reg         <= '0;
         n_lat_reg      <= '0;
         r_reg          <= '0;
         t_reg          <= '0;
         err_reg        <= 1'b0;
         miss_reg       <= 1'b0;
         flush_flag_reg <= 1'b0;
         cache_vld_reg  <= 1'b0;
         cache_n_reg    <= '0;
         cache_r_reg    <= '0;
         cache_t_reg    <= '0;
      end else begin
         if (latch) begin
            id_reg    <= grant_id;
            n_lat_reg <= n_sel;
            err_reg   <= 1'b0;
         end
         if (state_reg == ST_LOOKUP) miss_reg <= !hit;
         if (hit) begin
            r_reg <= cache_r_reg;
            t_reg <= cache_t_reg;
         end
         if (cap_r) r_reg <= eng_r;
         if (cap_t) t_reg <= eng_r;
         if (timeout) begin
            err_reg <= 1'b1;
            r_reg   <= '0;
            t_reg   <= '0;
         end

         if (state_reg == ST_RSP) begin
            flush_flag_reg <= 1'b0;
         end else if (cache_flush && in_flight) begin
            flush_flag_reg <= 1'b1;
         end

         if (cache_write) begin
            cache_n_reg <= n_lat_reg;
            cache_r_reg <= r_reg;
            cache_t_reg <= t_reg;
         end
         // Flush and timeout take precedence over a same-cycle cache fill.
         if (cache_flush || timeout) begin
            cache_vld_reg <= 1'b0;
         end else if (cache_write) begin
            cache_vld_reg <= 1'b1;
         end
      end
   end

   assign rsp_r    = r_reg;
   assign rsp_t    = t_reg;
   assign rsp_err  = err_reg;
   assign eng_go   = (state_reg == ST_GO_R) || (state_reg == ST_GO_T);
   assign eng_mode = ((state_reg == ST_GO_T) || (state_reg == ST_WAIT_T)) ? OP_T : OP_R;
   assign eng_n    = n_lat_reg;

endmodule

// File: tb/tb_rt_param_ctrl.sv
// Directed bench for rt_param_ctrl with a behavioural rtMod engine (RSA_WIDTH=8).
module tb_rt_param_ctrl;

   localparam int W  = 8;
   localparam int NR = 2;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req_valid;
   logic [NR*W-1:0] req_n;
   logic          cache_flush;
   logic [NR-1:0] ack;
   logic [W-1:0]  rsp_r, rsp_t;
   logic          rsp_err, eng_go, eng_mode;
   logic [W-1:0]  eng_n;
   logic [W-1:0]  eng_r = '0;
   logic          eng_done = 1'b0;

   int checks = 0;
   int errors = 0;

   logic          eng_dead = 1'b0;
   int            eng_lat  = 2;
   int            eng_cnt  = 0;
   logic          eng_m    = 1'b0;
   logic [W-1:0]  eng_nl   = '0;

   always #5 clk = ~clk;

   rt_param_ctrl #(
      .RSA_WIDTH   (W),
      .NUM_REQ     (NR),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_n       (req_n),
      .cache_flush (cache_flush),
      .ack         (ack),
      .rsp_r       (rsp_r),
      .rsp_t       (rsp_t),
      .rsp_err     (rsp_err),
      .eng_go      (eng_go),
      .eng_mode    (eng_mode),
      .eng_n       (eng_n),
      .eng_r       (eng_r),
      .eng_done    (eng_done)
   );

   // rtMod model: mode R gives 2^W mod n, mode T gives 2^(2W) mod n (= r^2 mod n).
   always @(posedge clk) begin
      if (eng_go) begin
         eng_done <= 1'b0;
         eng_cnt  <= eng_lat;
         eng_m    <= eng_mode;
         eng_nl   <= eng_n;
      end else if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1 && !eng_dead) begin
            eng_done <= 1'b1;
            eng_r    <= W'((eng_m ? 65536 : 256) % int'(eng_nl));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // c >= 0: raise a request for client c with modulus n in the next IDLE cycle.
   // exp_lat < 0 skips the latency comparison.
   task automatic txn(input int c, input logic [W-1:0] n, input logic flush_t,
                      input logic [NR-1:0] exp_ack, input logic [W-1:0] exp_r,
                      input logic [W-1:0] exp_t, input logic exp_err,
                      input int exp_gos, input int exp_lat);
      int            lat;
      int            gos;
      logic [1:0]    modes;
      logic          flushed;
      logic [NR-1:0] a;
      logic [W-1:0]  r, t;
      logic          e;
      lat = 0; gos = 0; modes = '0; flushed = 1'b0; a = '0; r = '0; t = '0; e = 1'b0;
      if (c >= 0) begin
         tick();
         req_n[c*W +: W] = n;
         req_valid[c]    = 1'b1;
      end
      while (lat < 200) begin
         tick();
         lat++;
         cache_flush = 1'b0;
         if (eng_go) begin
            if (gos < 2) modes[gos] = eng_mode;
            gos++;
         end
         if (flush_t && !flushed && eng_mode && !eng_go) begin
            cache_flush = 1'b1;
            flushed     = 1'b1;
         end
         if (ack != '0) begin
            a = ack; r = rsp_r; t = rsp_t; e = rsp_err;
            req_valid = req_valid & ~ack;
            break;
         end
      end
      cache_flush = 1'b0;
      $display("txn ack=%b r=%0d t=%0d err=%0d go_count=%0d latency=%0d", a, r, t, e, gos, lat);
      chk("ack_seen", 32'(a != '0), 1);
      chk("ack_client", 32'(a), 32'(exp_ack));
      chk("rsp_r", 32'(r), 32'(exp_r));
      chk("rsp_t", 32'(t), 32'(exp_t));
      chk("rsp_err", 32'(e), 32'(exp_err));
      chk("go_count", 32'(gos), 32'(exp_gos));
      if (exp_gos == 2) chk("go_modes", 32'(modes), 32'b10);
      if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      req_valid   = '0;
      cache_flush = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int seen;
      rst_n       = 1'b0;
      req_valid   = '0;
      req_n       = '0;
      cache_flush = 1'b0;
      tick();
      tick();
      chk("rst_ack", 32'(ack), 0);
      chk("rst_go", 32'(eng_go), 0);
      chk("rst_mode", 32'(eng_mode), 0);
      chk("rst_eng_n", 32'(eng_n), 0);
      chk("rst_r", 32'(rsp_r), 0);
      chk("rst_t", 32'(rsp_t), 0);
      chk("rst_err", 32'(rsp_err), 0);
      rst_n = 1'b1;
      tick();

      // Miss then hit for n=13 from both clients.
      txn(0, 8'd13, 1'b0, 2'b01, 8'd9, 8'd3, 1'b0, 2, 10);
      txn(1, 8'd13, 1'b0, 2'b10, 8'd9, 8'd3, 1'b0, 0, 2);

      // Simultaneous requests after reset: client 0 first, then client 1 misses.
      do_reset();
      req_n     = {8'd13, 8'd11};
      req_valid = 2'b11;
      txn(-1, 8'd0, 1'b0, 2'b01, 8'd3, 8'd9, 1'b0, 2, 10);
      txn(-1, 8'd0, 1'b0, 2'b10, 8'd9, 8'd3, 1'b0, 2, -1);

      // Flush during WAIT_T: result returned but not cached.
      txn(0, 8'd11, 1'b1, 2'b01, 8'd3, 8'd9, 1'b0, 2, 10);
      txn(0, 8'd11, 1'b0, 2'b01, 8'd3, 8'd9, 1'b0, 2, 10);
      txn(0, 8'd11, 1'b0, 2'b01, 8'd3, 8'd9, 1'b0, 0, 2);

      // Flush while idle invalidates the cached 11.
      tick();
      cache_flush = 1'b1;
      tick();
      cache_flush = 1'b0;
      txn(0, 8'd11, 1'b0, 2'b01, 8'd3, 8'd9, 1'b0, 2, 10);
      txn(0, 8'd11, 1'b0, 2'b01, 8'd3, 8'd9, 1'b0, 0, 2);

      // Engine never finishes: timeout on wait cycle 20, cache invalidated.
      eng_dead = 1'b1;
      txn(0, 8'd7, 1'b0, 2'b01, 8'd0, 8'd0, 1'b1, 1, 23);
      eng_dead = 1'b0;
      txn(0, 8'd11, 1'b0, 2'b01, 8'd3, 8'd9, 1'b0, 2, 10);

      // Reset asserted in WAIT_R aborts at once.
      tick();
      req_n[W-1:0] = 8'd13;
      req_valid    = 2'b01;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         tick();
         if (eng_go) seen = 1;
      end
      chk("abort_go_seen", 32'(seen), 1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("abort_ack", 32'(ack), 0);
      chk("abort_go", 32'(eng_go), 0);
      chk("abort_mode", 32'(eng_mode), 0);
      chk("abort_eng_n", 32'(eng_n), 0);
      chk("abort_r", 32'(rsp_r), 0);
      chk("abort_t", 32'(rsp_t), 0);
      chk("abort_err", 32'(rsp_err), 0);
      req_valid = '0;
      tick();
      rst_n = 1'b1;
      txn(0, 8'd13, 1'b0, 2'b01, 8'd9, 8'd3, 1'b0, 2, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
